// File: rtl/l0_feeder.sv
// l0_feeder: streams a run of consecutive SRAM words into the L0 row FIFO.
// One read may be issued per cycle. Read data arrives one cycle later and is
// held in a 2-entry skid buffer, which L0 drains whenever it is ready.
// A read is only issued when the data it returns is guaranteed a free skid slot.
module l0_feeder #(
  parameter int ROW    = 8,
  parameter int BW     = 4,
  parameter int ADDR_W = 11,
  localparam int W     = ROW * BW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W:0]   i_num_words,
  output logic              o_sram_cen,
  output logic              o_sram_wen,
  output logic [ADDR_W-1:0] o_sram_a,
  input  logic [W-1:0]      i_sram_q,
  input  logic              i_l0_ready,
  output logic              o_l0_wr,
  output logic [W-1:0]      o_l0_in,
  output logic              o_busy,
  output logic              o_done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_num;
  logic [ADDR_W:0]     r_ic;        // reads issued
  logic [ADDR_W:0]     r_wc;        // L0 writes done
  logic                r_inflight;  // a read was issued last cycle
  logic [1:0]          r_sc;        // skid occupancy, 0..2
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [W-1:0]        r_skid [2];
  logic [ADDR_W-1:0]   r_a_hold;    // last issued address

  logic                w_start_ok;
  logic                w_pop;
  logic                w_room;
  logic                w_issue;
  logic [ADDR_W-1:0]   w_addr;
  logic [ADDR_W:0]     w_wc_next;

  assign w_start_ok = (r_state == S_IDLE) && i_start;

  // L0 write whenever the skid holds a word and L0 can take it.
  assign w_pop = (r_sc != 2'd0) && i_l0_ready;

  // After this cycle's pop, skid words plus any pending read must leave a slot
  // for the read we are about to issue.
  assign w_room    = ({1'b0, r_sc} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop});
  assign w_issue   = (r_state == S_RUN) && (r_ic < r_num) && w_room;
  assign w_addr    = r_base + r_ic[ADDR_W-1:0];
  assign w_wc_next = r_wc + {{ADDR_W{1'b0}}, w_pop};

  assign o_sram_cen = ~w_issue;
  assign o_sram_wen = 1'b1;
  assign o_sram_a   = w_issue ? w_addr : r_a_hold;
  assign o_l0_wr    = w_pop;
  assign o_l0_in    = r_skid[r_rd_ptr];
  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic: leave RUN the cycle the final L0 write happens.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_next = (i_num_words == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_wc_next == r_num) w_state_next = S_DONE;
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Transfer parameters latched on an accepted start; counters advance in RUN.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_base <= '0;
      r_num  <= '0;
      r_ic   <= '0;
      r_wc   <= '0;
    end else if (w_start_ok) begin
      r_base <= i_base_addr;
      r_num  <= i_num_words;
      r_ic   <= '0;
      r_wc   <= '0;
    end else if (r_state == S_RUN) begin
      r_ic <= r_ic + {{ADDR_W{1'b0}}, w_issue};
      r_wc <= w_wc_next;
    end
  end

  // Address hold register keeps sram_a stable between reads.
  always_ff @(posedge i_clk) begin
    if (i_reset)      r_a_hold <= '0;
    else if (w_issue) r_a_hold <= w_addr;
  end

  // Read-latency tracking, skid occupancy and FIFO pointers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_inflight <= 1'b0;
      r_sc       <= 2'd0;
      r_rd_ptr   <= 1'b0;
      r_wr_ptr   <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      r_sc       <= r_sc + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Skid entries: returning SRAM data lands in the tail slot.
  for (genvar gi = 0; gi < 2; gi++) begin : g_skid
    always_ff @(posedge i_clk) begin
      if (i_reset)                                  r_skid[gi] <= '0;
      else if (r_inflight && (r_wr_ptr == 1'(gi)))  r_skid[gi] <= i_sram_q;
    end
  end

endmodule

// File: tb/tb_l0_feeder.sv
// Directed bench for l0_feeder with a one-cycle-latency SRAM model.
module tb_l0_feeder;

  localparam int AW = 11;
  localparam int W  = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [W-1:0]  sram_q;
  logic          l0_ready;
  logic          l0_wr;
  logic [W-1:0]  l0_in;
  logic          busy;
  logic          done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  l0_feeder #(.ROW(8), .BW(4), .ADDR_W(AW)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_num_words (num_words),
    .o_sram_cen  (sram_cen),
    .o_sram_wen  (sram_wen),
    .o_sram_a    (sram_a),
    .i_sram_q    (sram_q),
    .i_l0_ready  (l0_ready),
    .o_l0_wr     (l0_wr),
    .o_l0_in     (l0_in),
    .o_busy      (busy),
    .o_done      (done)
  );

  function automatic logic [31:0] word_of(input logic [AW-1:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // SRAM: registered read, data valid the cycle after cen low.
  initial sram_q = '0;
  always @(posedge clk) begin
    if (!sram_cen) sram_q <= word_of(sram_a);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One transfer; cycle 0 is the cycle start is high.
  task automatic run_xfer(input string tag, input logic [AW-1:0] base, input logic [AW:0] n,
                          input logic [31:0] stall_mask, input int exp_done,
                          input int reset_cyc, input int restart_cyc);
    int rd;
    int wr;
    int dones;
    logic [AW-1:0] ea;
    logic exp_busy;
    rd = 0;
    wr = 0;
    dones = 0;
    for (int cyc = 0; cyc <= exp_done + 2 && cyc < 200; cyc++) begin
      @(negedge clk);
      start = (cyc == 0) || (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        base_addr = 11'h000;
        num_words = 12'd3;
      end else begin
        base_addr = base;
        num_words = n;
      end
      l0_ready = (cyc < 32) ? ~stall_mask[cyc] : 1'b1;
      reset    = (cyc == reset_cyc);
      #1;
      if (reset_cyc >= 0 && cyc == reset_cyc + 1) begin
        chk({tag, " busy after reset"}, 64'(busy), 64'd0);
        chk({tag, " cen after reset"}, 64'(sram_cen), 64'd1);
        chk({tag, " l0_wr after reset"}, 64'(l0_wr), 64'd0);
        break;
      end
      chk({tag, " wen"}, 64'(sram_wen), 64'd1);
      if (!sram_cen) begin
        ea = base + 11'(rd);
        chk({tag, " read addr"}, 64'(sram_a), 64'(ea));
        if (stall_mask == 0) chk({tag, " read cycle"}, 64'(cyc), 64'(rd + 1));
        rd++;
      end
      if (l0_wr) begin
        chk({tag, " wr while not ready"}, 64'(l0_ready), 64'd1);
        chk({tag, " l0 data"}, 64'(l0_in), 64'(word_of(base + 11'(wr))));
        if (stall_mask == 0) chk({tag, " write cycle"}, 64'(cyc), 64'(wr + 3));
        $display("%s: cycle %0d L0 word %0d = 0x%08h", tag, cyc, wr, l0_in);
        wr++;
      end
      if (reset_cyc >= 0) exp_busy = (cyc >= 1) && (cyc <= reset_cyc);
      else                exp_busy = (n != 0) && (cyc >= 1) && (cyc < exp_done);
      chk({tag, " busy"}, 64'(busy), 64'(exp_busy));
      if (reset_cyc < 0) chk({tag, " done"}, 64'(done), 64'(cyc == exp_done));
      if (done) dones++;
    end
    start    = 1'b0;
    reset    = 1'b0;
    l0_ready = 1'b1;
    if (reset_cyc < 0) begin
      chk({tag, " read count"}, 64'(rd), 64'(n));
      chk({tag, " write count"}, 64'(wr), 64'(n));
      chk({tag, " done count"}, 64'(dones), 64'd1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    num_words = '0;
    l0_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset cen", 64'(sram_cen), 64'd1);
    chk("reset wen", 64'(sram_wen), 64'd1);
    chk("reset addr", 64'(sram_a), 64'd0);
    chk("reset l0_wr", 64'(l0_wr), 64'd0);
    chk("reset l0_in", 64'(l0_in), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);

    // base, N, ready-low mask, done cycle, reset cycle, restart cycle
    run_xfer("basic",   11'h010, 12'd8,  32'h0,    11, -1, -1);
    run_xfer("backpr",  11'h100, 12'd16, 32'h43E0, 25, -1, -1);
    run_xfer("zero",    11'h055, 12'd0,  32'h0,    1,  -1, -1);
    run_xfer("wrap",    11'h7FE, 12'd4,  32'h0,    7,  -1, -1);
    run_xfer("rstmid",  11'h020, 12'd8,  32'h0,    20, 4,  -1);
    run_xfer("postrst", 11'h030, 12'd2,  32'h0,    5,  -1, -1);
    run_xfer("restart", 11'h040, 12'd8,  32'h0,    11, -1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l0_feeder.md
# l0_feeder

Read sequencer between the activation/weight SRAM and the L0 row-FIFO buffer. On a start pulse it streams `num_words` consecutive SRAM words (row*bw bits each) from `base_addr` into L0, one write per cycle at full rate. It absorbs the SRAM's one-cycle read latency and L0 backpressure with a 2-entry skid buffer, so no word is dropped or duplicated.

## Interface
- `row`, 8, lanes per word (matches L0 row count)
- `bw`, 4, bits per lane; word width W = row*bw
- `addr_w`, 11, SRAM address width
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  addr_w  first SRAM address; latched on accepted start
- `num_words`  in  addr_w+1  words to transfer (0..2^addr_w); latched on accepted start
- `sram_cen`  out  1  SRAM chip enable, active-low; low = read issued this cycle
- `sram_wen`  out  1  SRAM write enable, active-low; tied 1
- `sram_a`  out  addr_w  SRAM address
- `sram_q`  in  W  SRAM read data; valid the cycle after `sram_cen` low
- `l0_ready`  in  1  L0 `o_ready` (not full)
- `l0_wr`  out  1  L0 write strobe
- `l0_in`  out  W  L0 write data
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse

## Operation
- FSM: IDLE -> RUN on `start`; RUN -> DONE once all words are written; DONE -> IDLE unconditionally after one cycle.
- IDLE: `start`=1 latches `base_addr` and `num_words`, then enters RUN. If `num_words`=0, it goes straight to DONE.
- Counters:
  - issue count `ic` (reads issued)
  - write count `wc` (L0 writes)
  - `inflight` flag: a read was issued last cycle
  - skid occupancy `sc` (0..2)
- Pop: `l0_wr = (sc>0) & l0_ready`, combinational. `l0_in` = skid head word.
- Issue: in RUN, if `ic < num_words` and `sc + inflight - l0_wr < 2`, then drive `sram_cen`=0 and `sram_a = base_addr + ic` (mod 2^addr_w); `ic` increments.
- Capture: when `inflight`=1, `sram_q` is pushed into the skid tail that cycle.
  - Push and pop in the same cycle: `sc` unchanged, FIFO order kept.
- `wc` increments on each `l0_wr`. RUN -> DONE when `wc` reaches `num_words` (the cycle after the final write).
- When no read is issued: `sram_cen`=1 and `sram_a` holds its last value.
- `start` in RUN or DONE is ignored.
- `sram_wen` is always 1; the block never writes SRAM.
- `reset` (any state, including mid-transfer) returns the block to IDLE:
  - counters, `sc` and `inflight` cleared
  - skid contents discarded
  - L0 must be reset alongside.

## Timing
- Reset values:
  - `sram_cen`=1, `sram_wen`=1, `sram_a`=0
  - `l0_wr`=0 (skid empty), `l0_in`=0
  - `busy`=0, `done`=0
- `start` high in cycle 0 gives:
  - cycle 1: first read (`sram_cen`=0, `sram_a`=base)
  - cycle 2: data captured
  - cycle 3: first `l0_wr`
- No backpressure, N≥1:
  - reads in cycles 1..N
  - writes in cycles 3..N+2
  - `done`=1 in cycle N+3
  - `busy`=1 in cycles 1..N+2
- Steady-state throughput: 1 word/cycle.
- `l0_ready`=0 holds `l0_wr`=0. Issue stalls once `sc+inflight` reaches 2. An in-flight read always has a free skid slot.
- `done`: exactly one cycle, with `busy`=0 in that cycle. A new `start` is accepted in the following cycle (IDLE).
- `num_words`=0: `done` in cycle 1; `sram_cen` stays 1.
- Address wrap: base+ic past 2^addr_w-1 continues at 0.

## Test plan
- Basic: base=0x010, N=8, `l0_ready`=1, SRAM[a]=a*0x01010101:
  - reads cycles 1–8
  - L0 receives words for 0x010..0x017 in order, cycles 3–10
  - `done` in cycle 11.
- Backpressure: N=16, `l0_ready` low for cycles 5–9 and 14:
  - all 16 words arrive in order, no duplicates
  - `sc` never exceeds 2
  - `l0_wr` never high while `l0_ready`=0.
- Zero length: N=0 -> no `sram_cen` low, `l0_wr` stays 0, `done` in cycle 1.
- Wrap: base=0x7FE, N=4 -> addresses 0x7FE, 0x7FF, 0x000, 0x001.
- Reset mid-transfer: reset in cycle 4 of an N=8 run:
  - next cycle `busy`=0, `sram_cen`=1, `l0_wr`=0
  - a fresh start with N=2 then transfers exactly 2 words.
- Start while busy: second `start` in cycle 3 of an N=8 run -> ignored; exactly 8 writes and a single `done`.
